// File: rtl/disp_pkg.sv
// Shared mode encodings and bus-slicing helper for the display multiplexer.
package disp_pkg;

   localparam logic [1:0] DM_MANUAL = 2'd0;
   localparam logic [1:0] DM_AUTO   = 2'd1;
   localparam logic [1:0] DM_SNAP   = 2'd2;

   // LSB position of channel ch on a flattened bus of w-bit slices.
   function automatic int ch_lsb(input int ch, input int w);
      return ch * w;
   endfunction

endpackage

// File: rtl/rr_next.sv
// Combinational next-set-bit finder: first set mask bit strictly after i_start, wrapping.
// Returns i_start itself only when it is the sole set bit; o_found=0 when the mask is empty.
module rr_next #(
   parameter int NCH = 8,
   parameter int CW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] i_mask,
   input  logic [CW-1:0]  i_start,
   output logic [CW-1:0]  o_idx,
   output logic           o_found
);

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int d = NCH; d >= 1; d--) begin
         if (i_mask[(int'(i_start) + d) % NCH]) begin
            o_idx   = CW'((int'(i_start) + d) % NCH);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_mux_nch.sv
// N-channel seven-segment source selector: manual select, auto rotation, or auto snapshot.
// Outputs registered one clock after inputs; no backpressure, EN=0 freezes all state.
module disp_mux_nch
   import disp_pkg::*;
#(
   parameter int NCH = 8,
   parameter int DW  = 32,
   parameter int PW  = 8,
   parameter int LW  = 8,
   parameter int CW  = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              RSTN,
   input  logic              EN,
   input  logic [1:0]        mode,
   input  logic [CW-1:0]     sel,
   input  logic              tick,
   input  logic [7:0]        dwell,
   input  logic [NCH-1:0]    mask,
   input  logic [NCH*DW-1:0] data_in,
   input  logic [NCH*PW-1:0] point_in,
   input  logic [NCH*LW-1:0] les_in,
   output logic [DW-1:0]     Disp_num,
   output logic [PW-1:0]     point_out,
   output logic [LW-1:0]     LE_out,
   output logic [CW-1:0]     cur_ch,
   output logic              ch_valid,
   output logic              ch_switch
);

   logic [1:0]    r_mode;
   logic [7:0]    r_cnt;
   logic [CW-1:0] r_cur_ch;
   logic [DW-1:0] r_disp;
   logic [PW-1:0] r_point;
   logic [LW-1:0] r_le;
   logic          r_valid;
   logic          r_switch;

   logic          w_auto;
   logic          w_live;
   logic          w_mode_chg;
   logic          w_term;
   logic          w_cur_en;
   logic          w_nxt_en;
   logic          w_nxt_hit;
   logic          w_rr_found;
   logic          w_load;
   logic          w_valid_nxt;
   logic [7:0]    w_dwell_eff;
   logic [7:0]    w_cnt_nxt;
   logic [8:0]    w_cnt_inc;
   logic [CW-1:0] w_cur_nxt;
   logic [CW-1:0] w_rr_idx;
   logic [DW-1:0] w_dat;
   logic [PW-1:0] w_pt;
   logic [LW-1:0] w_le;

   assign w_auto      = (mode == DM_AUTO) || (mode == DM_SNAP);
   assign w_live      = (mode == DM_AUTO);
   assign w_mode_chg  = (mode != r_mode);
   assign w_dwell_eff = (dwell == 8'd0) ? 8'd1 : dwell;
   assign w_cnt_inc   = {1'b0, r_cnt} + 9'd1;
   assign w_term      = tick && (w_cnt_inc >= {1'b0, w_dwell_eff});

   rr_next #(.NCH(NCH), .CW(CW)) u_rr_next (
      .i_mask  (mask),
      .i_start (r_cur_ch),
      .o_idx   (w_rr_idx),
      .o_found (w_rr_found)
   );

   always_comb begin
      w_cur_en = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (CW'(k) == r_cur_ch) w_cur_en = mask[k];
      end
   end

   // A mode change outranks a terminal tick: counter restarts, channel stays.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_cur_nxt = r_cur_ch;
      if (!w_auto) begin
         w_cnt_nxt = '0;
         w_cur_nxt = sel;
      end else if (w_mode_chg) begin
         w_cnt_nxt = '0;
      end else if (tick) begin
         if (!w_cur_en || w_term) begin
            w_cnt_nxt = '0;
            if (w_rr_found) w_cur_nxt = w_rr_idx;
         end else begin
            w_cnt_nxt = w_cnt_inc[7:0];
         end
      end
   end

   always_comb begin
      w_dat     = '0;
      w_pt      = '0;
      w_le      = '0;
      w_nxt_hit = 1'b0;
      w_nxt_en  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (CW'(k) == w_cur_nxt) begin
            w_dat     = data_in[ch_lsb(k, DW) +: DW];
            w_pt      = point_in[ch_lsb(k, PW) +: PW];
            w_le      = les_in[ch_lsb(k, LW) +: LW];
            w_nxt_hit = 1'b1;
            w_nxt_en  = mask[k];
         end
      end
   end

   assign w_load      = !w_auto ||
                        ((mask != '0) && (w_live || w_mode_chg || (w_cur_nxt != r_cur_ch)));
   assign w_valid_nxt = w_auto ? w_nxt_en : w_nxt_hit;

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         r_mode   <= DM_MANUAL;
         r_cnt    <= '0;
         r_cur_ch <= '0;
         r_disp   <= '0;
         r_point  <= '0;
         r_le     <= '0;
         r_valid  <= 1'b0;
         r_switch <= 1'b0;
      end else if (!EN) begin
         r_switch <= 1'b0;
      end else begin
         r_mode   <= mode;
         r_cnt    <= w_cnt_nxt;
         r_cur_ch <= w_cur_nxt;
         r_valid  <= w_valid_nxt;
         r_switch <= (w_cur_nxt != r_cur_ch);
         if (w_load) begin
            r_disp  <= w_dat;
            r_point <= w_pt;
            r_le    <= w_le;
         end
      end
   end

   assign Disp_num  = r_disp;
   assign point_out = r_point;
   assign LE_out    = r_le;
   assign cur_ch    = r_cur_ch;
   assign ch_valid  = r_valid;
   assign ch_switch = r_switch & EN;

endmodule

// File: tb/tb_disp_mux_nch.sv
// Directed-sequence bench with randomized channel data, checked every cycle against a behavioural model.
module tb_disp_mux_nch;

   logic         clk;
   logic         RSTN;
   logic         EN;
   logic [1:0]   mode;
   logic [2:0]   sel;
   logic         tick;
   logic [7:0]   dwell;
   logic [7:0]   mask;
   logic [255:0] data_in;
   logic [63:0]  point_in;
   logic [63:0]  les_in;
   logic [31:0]  Disp_num;
   logic [7:0]   point_out;
   logic [7:0]   LE_out;
   logic [2:0]   cur_ch;
   logic         ch_valid;
   logic         ch_switch;

   int n_tests;
   int n_fail;
   bit rnd_data;
   int ch_log[$];

   // behavioural model state
   logic [31:0] m_disp;
   logic [7:0]  m_pt;
   logic [7:0]  m_le;
   int          m_cur;
   int          m_ticks;
   bit          m_valid;
   bit          m_sw;
   logic [1:0]  m_prev;

   disp_mux_nch #(.NCH(8), .DW(32), .PW(8), .LW(8)) dut (
      .clk       (clk),
      .RSTN      (RSTN),
      .EN        (EN),
      .mode      (mode),
      .sel       (sel),
      .tick      (tick),
      .dwell     (dwell),
      .mask      (mask),
      .data_in   (data_in),
      .point_in  (point_in),
      .les_in    (les_in),
      .Disp_num  (Disp_num),
      .point_out (point_out),
      .LE_out    (LE_out),
      .cur_ch    (cur_ch),
      .ch_valid  (ch_valid),
      .ch_switch (ch_switch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int next_on(input int from, input logic [7:0] mk);
      for (int d = 1; d <= 8; d++) begin
         if (mk[(from + d) % 8]) return (from + d) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_disp  = '0;
      m_pt    = '0;
      m_le    = '0;
      m_cur   = 0;
      m_ticks = 0;
      m_valid = 1'b0;
      m_sw    = 1'b0;
      m_prev  = 2'd0;
   endtask

   // Next model state from the inputs about to be sampled at the coming edge.
   task automatic model_update();
      int old_ch;
      int lim;
      int nx;
      bit is_auto;
      bit mchg;
      bit do_load;
      if (!RSTN) begin
         model_reset();
         return;
      end
      if (!EN) begin
         m_sw = 1'b0;
         return;
      end
      is_auto = (mode == 2'd1) || (mode == 2'd2);
      mchg    = (mode != m_prev);
      old_ch  = m_cur;
      lim     = (dwell == 8'd0) ? 1 : int'(dwell);
      if (!is_auto) begin
         m_cur   = int'(sel);
         m_ticks = 0;
      end else if (mchg) begin
         m_ticks = 0;
      end else if (tick) begin
         m_ticks++;
         if (!mask[m_cur] || m_ticks >= lim) begin
            m_ticks = 0;
            nx = next_on(m_cur, mask);
            if (nx >= 0) m_cur = nx;
         end
      end
      do_load = !is_auto || (mask != 8'h00 && (mode == 2'd1 || mchg || m_cur != old_ch));
      if (do_load) begin
         m_disp = data_in[m_cur*32 +: 32];
         m_pt   = point_in[m_cur*8 +: 8];
         m_le   = les_in[m_cur*8 +: 8];
      end
      m_valid = is_auto ? mask[m_cur] : 1'b1;
      m_sw    = (m_cur != old_ch);
      m_prev  = mode;
   endtask

   task automatic check_all();
      chk("disp",   Disp_num, m_disp);
      chk("point",  32'(point_out), 32'(m_pt));
      chk("le",     32'(LE_out), 32'(m_le));
      chk("cur",    32'(cur_ch), 32'(m_cur));
      chk("valid",  32'(ch_valid), 32'(m_valid));
      chk("switch", 32'(ch_switch), 32'(m_sw));
      if (ch_switch) ch_log.push_back(int'(cur_ch));
   endtask

   task automatic step();
      int c;
      if (rnd_data && $urandom_range(3) == 0) begin
         c = $urandom_range(7);
         data_in[c*32 +: 32] = $urandom();
         point_in[c*8 +: 8]  = 8'($urandom());
         les_in[c*8 +: 8]    = 8'($urandom());
      end
      model_update();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run(input int n, input int period);
      for (int i = 0; i < n; i++) begin
         tick = (i % period == period - 1);
         step();
      end
      tick = 1'b0;
   endtask

   logic [31:0] v;
   logic [31:0] cap;
   logic [31:0] d3;
   logic [31:0] h_disp;
   int          h_cur;

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rnd_data = 1'b0;
      RSTN = 1'b0; EN = 1'b1; mode = 2'd0; sel = 3'd0; tick = 1'b0; dwell = 8'd0; mask = 8'h00;
      for (int c = 0; c < 8; c++) begin
         data_in[c*32 +: 32] = $urandom();
         point_in[c*8 +: 8]  = 8'($urandom());
         les_in[c*8 +: 8]    = 8'($urandom());
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_disp", Disp_num, 32'h0);
      chk("rst_cur", 32'(cur_ch), 32'h0);
      chk("rst_valid", 32'(ch_valid), 32'h0);
      chk("rst_switch", 32'(ch_switch), 32'h0);
      RSTN = 1'b1;

      // manual select
      sel = 3'd2;
      data_in[2*32 +: 32] = 32'h0000_1234;
      step();
      chk("man_disp", Disp_num, 32'h0000_1234);
      chk("man_cur", 32'(cur_ch), 32'd2);
      chk("man_sw_pulse", 32'(ch_switch), 32'd1);
      step();
      chk("man_sw_clear", 32'(ch_switch), 32'd0);
      for (int i = 0; i < 6; i++) begin
         sel = 3'($urandom_range(7));
         data_in[int'(sel)*32 +: 32] = $urandom();
         step();
      end

      // auto live rotation over mask 1011
      sel = 3'd0;
      step();
      mask = 8'b0000_1011; dwell = 8'd2; mode = 2'd1;
      ch_log.delete();
      run(36, 4);
      chk("live_nsw", 32'(ch_log.size()), 32'd4);
      chk("live_seq0", 32'(ch_log[0]), 32'd1);
      chk("live_seq1", 32'(ch_log[1]), 32'd3);
      chk("live_seq2", 32'(ch_log[2]), 32'd0);
      v = $urandom();
      data_in[1*32 +: 32] = v;
      step();
      chk("live_follow", Disp_num, v);

      // snapshot holds the captured value
      mode = 2'd2;
      step();
      cap = v;
      data_in[1*32 +: 32] = ~v;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("snap_hold", Disp_num, cap);
      end
      run(8, 4);
      chk("snap_sw_cur", 32'(cur_ch), 32'd3);
      d3 = data_in[3*32 +: 32];
      chk("snap_sw_disp", Disp_num, d3);

      // empty mask freezes, then a single new channel is reached on the next tick
      mask = 8'h00;
      run(12, 4);
      chk("mask0_cur", 32'(cur_ch), 32'd3);
      chk("mask0_valid", 32'(ch_valid), 32'd0);
      chk("mask0_disp", Disp_num, d3);
      mask = 8'h10;
      run(4, 4);
      chk("mask10_cur", 32'(cur_ch), 32'd4);
      chk("mask10_valid", 32'(ch_valid), 32'd1);
      chk("mask10_disp", Disp_num, data_in[4*32 +: 32]);

      // dwell 0 advances on every tick
      rnd_data = 1'b1;
      mask = 8'hFF; dwell = 8'd0; mode = 2'd1;
      step();
      run(8, 2);
      chk("dwell0_cur", 32'(cur_ch), 32'd0);

      // mode change on a terminal tick: no advance, counter restarts
      dwell = 8'd2; mode = 2'd2;
      step();
      tick = 1'b1; step(); tick = 1'b0; step();
      mode = 2'd1; tick = 1'b1; step(); tick = 1'b0;
      chk("mchg_noadv", 32'(cur_ch), 32'd0);
      step();
      tick = 1'b1; step(); tick = 1'b0;
      chk("mchg_restart", 32'(cur_ch), 32'd0);
      step();
      tick = 1'b1; step(); tick = 1'b0;
      chk("mchg_adv", 32'(cur_ch), 32'd1);

      // single enabled channel never switches away
      dwell = 8'd1; mask = 8'h04;
      run(4, 2);
      chk("single_cur", 32'(cur_ch), 32'd2);
      ch_log.delete();
      run(8, 2);
      chk("single_nsw", 32'(ch_log.size()), 32'd0);

      // EN low for 10 ticks holds everything
      mask = 8'hFF;
      run(4, 2);
      h_disp = m_disp;
      h_cur  = m_cur;
      EN = 1'b0;
      run(40, 4);
      chk("en_disp", Disp_num, h_disp);
      chk("en_cur", 32'(cur_ch), 32'(h_cur));
      chk("en_switch", 32'(ch_switch), 32'd0);
      EN = 1'b1;
      run(4, 2);

      // asynchronous reset mid-rotation
      run(5, 2);
      RSTN = 1'b0;
      #2;
      chk("arst_disp", Disp_num, 32'h0);
      chk("arst_point", 32'(point_out), 32'h0);
      chk("arst_le", 32'(LE_out), 32'h0);
      chk("arst_cur", 32'(cur_ch), 32'h0);
      chk("arst_valid", 32'(ch_valid), 32'h0);
      chk("arst_switch", 32'(ch_switch), 32'h0);
      model_reset();
      step();
      RSTN = 1'b1;
      ch_log.delete();
      step();
      chk("rel_cur", 32'(cur_ch), 32'd0);
      run(4, 2);
      chk("rel_nsw", 32'(ch_log.size()), 32'd2);
      chk("rel_first", 32'(ch_log[0]), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/disp_mux_nch.md
# disp_mux_nch

Parametrised N-channel display multiplexer for the seven-segment path in the flappy-bird game top. It generalises the fixed 8×32-bit channel selector to NCH channels of DW bits. Beyond manual switch selection, it adds an auto-cycle mode that rotates through enabled channels on a tick from `clkdiv`, and a snapshot mode that freezes each channel's value when it is selected. Outputs feed `Display`/`Seg7_Dev` directly (score, maxscore, Ai, Bi, …).

## Interface
- `NCH`, 8: number of channels (≥2).
- `DW`, 32: data width per channel.
- `PW`, 8: point-mask width per channel.
- `LW`, 8: LE (blank) mask width per channel.
- `CW`, `$clog2(NCH)`: channel index width (derived).

Ports:
- `clk` in 1: system clock.
- `RSTN` in 1: reset, asynchronous, active-low.
- `EN` in 1: global enable; 0 = every register holds.
- `mode` in 2: 0 manual, 1 auto live, 2 auto snapshot, 3 treated as manual.
- `sel` in CW: manual channel select.
- `tick` in 1: one-cycle pulse from the clock divider.
- `dwell` in 8: ticks per channel in auto modes; 0 is treated as 1.
- `mask` in NCH: channel enable for auto rotation.
- `data_in` in NCH*DW: flattened; channel k is at `[k*DW +: DW]`.
- `point_in` in NCH*PW: flattened point masks.
- `les_in` in NCH*LW: flattened LE masks.
- `Disp_num` out DW: selected data.
- `point_out` out PW: selected point mask.
- `LE_out` out LW: selected LE mask.
- `cur_ch` out CW: channel currently shown.
- `ch_valid` out 1: 1 when `cur_ch` is a legal, enabled channel.
- `ch_switch` out 1: one-cycle pulse when `cur_ch` changes.

## Operation
- Reset values: all outputs 0; dwell counter 0; previous-mode register 0.
- `EN`=0 holds every register. `ch_switch` is forced to 0 while `EN`=0.
- **Manual** (mode 0/3):
  - `cur_ch` ← `sel` every enabled cycle.
  - Outputs are loaded from channel `sel`.
  - `mask` is ignored. `ch_valid` = (`sel` < NCH).
  - If `sel` ≥ NCH, `cur_ch` takes `sel`, data outputs are 0, and `ch_valid`=0.
- **Auto live** (mode 1):
  - The dwell counter increments on `tick`.
  - When the counter reaches max(`dwell`,1) on a tick, it clears and `cur_ch` advances to the next set `mask` bit above `cur_ch`, wrapping to 0.
  - Outputs reload from `cur_ch` every cycle, so source changes are visible.
- **Auto snapshot** (mode 2): same advance rule, but outputs load only on the cycle `cur_ch` changes or the mode is entered. Otherwise they hold.
- Masked current channel: if `mask[cur_ch]`=0 in an auto mode, advance on the next `tick` regardless of the counter.
- Single enabled channel: if only `mask[cur_ch]` is set, no advance and no `ch_switch`.
- `mask`=0 in an auto mode: `cur_ch` holds, `ch_valid`=0, and data outputs hold their last value.
- Any change of `mode` clears the dwell counter. Auto rotation starts from the current `cur_ch`.
- `ch_switch`=1 on the cycle after the edge where `cur_ch` took a different value, in any mode.

## Timing
- All outputs are registered. Latency from `sel`/`data_in` to `Disp_num` is one clock.
- The advance takes effect at the clock edge where `tick`=1 and the counter equals max(`dwell`,1). `cur_ch` and the data for the new channel appear together after that edge.
- Simultaneous mode change and terminal tick: the mode change wins. The counter clears and there is no advance.
- `tick` held high for multiple cycles counts once per cycle; the source must pulse.
- Reset asserted mid-rotation returns everything to reset values immediately. After release, rotation resumes from channel 0.

## Structure
- Shared package `disp_pkg`:
  - mode constants `DM_MANUAL`=0, `DM_AUTO`=1, `DM_SNAP`=2.
  - a channel-slice function for the flattened buses.
- Sub-module `rr_next`: combinational next-set-bit finder over an NCH-bit mask from a start index, with wrap. It returns the index and a found flag.
- Top of block: dwell counter, mode register, channel register, output registers.

## Test plan
- Reset, then manual: `sel`=2 with ch2 data=32'h0000_1234 → `Disp_num`=32'h1234 and `cur_ch`=2 one cycle after; `ch_switch` pulses once.
- Auto live: `mask`=8'b0000_1011, `dwell`=2, tick every 4 clocks → `cur_ch` sequence 0,1,3,0 with a change every 2 ticks. `Disp_num` follows a mid-dwell change of ch1 data within one cycle.
- Auto snapshot: ch1 data changes while ch1 is displayed → `Disp_num` holds the captured value until the next switch.
- `mask`=0 in auto mode → `ch_valid`=0 and `cur_ch` frozen. Set `mask`=8'h10 → jump to ch4 on the next tick; `ch_valid`=1.
- `dwell`=0 → advance on every tick. A mode change on a terminal tick → no advance and the counter restarts.
- `EN`=0 for 10 ticks → nothing changes. `RSTN` pulse mid-rotation → all outputs 0; after release, rotation restarts at ch0.
